pc_fetch_unit: RTL and testbench

Program-counter register and instruction-fetch sequencer for the multi-cycle CPU; consumer side of the next-PC interface. It holds the architectural PC and commits the next-PC value when the control unit commands it. On request, it fetches the instruction at PC from instruction memory over a req/ack handshake and latches the result into the instruction register. Misaligned next-PC values and memory timeouts raise sticky error flags for the control unit.

---
 rtl/pc_fetch_unit.sv | 89 ++++++++
 tb/tb_pc_fetch_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: architectural PC register plus req/ack instruction fetch sequencer
// with sticky misalign and fetch-timeout flags.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_npc,
    input  logic        i_pc_wr,
    input  logic        i_fetch_start,
    output logic [31:0] o_pc,
    output logic [31:0] o_ir,
    output logic        o_ir_valid,
    output logic        o_busy,
    output logic        o_misalign,
    output logic        o_fetch_err,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_ack
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t      r_state, w_next;
    logic [7:0]  r_cnt;
    logic [31:0] r_pc, r_ir, r_imem_addr;
    logic        r_ir_valid, r_misalign, r_fetch_err, r_imem_req;
    logic        w_idle, w_pc_ok, w_pc_bad, w_start, w_ack, w_tmo;
    assign w_idle   = (r_state == IDLE);
    assign w_pc_ok  = w_idle && i_pc_wr && (i_npc[1:0] == 2'b00);
    assign w_pc_bad = w_idle && i_pc_wr && (i_npc[1:0] != 2'b00);
    assign w_start  = w_idle && i_fetch_start && !(r_misalign || r_fetch_err);
    assign w_ack    = !w_idle && i_imem_ack;
    // ack on the final WAIT edge takes priority over the timeout
    assign w_tmo    = !w_idle && !i_imem_ack && (r_cnt == 8'(TIMEOUT - 1));
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        if (w_idle) w_next = w_start ? WAIT : IDLE;
        else        w_next = (w_ack || w_tmo) ? IDLE : WAIT;
    end
    always_comb begin
        o_busy = (r_state == WAIT);
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pc        <= RESET_PC;
            r_ir        <= 32'h0;
            r_ir_valid  <= 1'b0;
            r_misalign  <= 1'b0;
            r_fetch_err <= 1'b0;
            r_imem_req  <= 1'b0;
            r_imem_addr <= RESET_PC;
            r_cnt       <= 8'h0;
        end else begin
            if (w_pc_ok) begin
                r_pc       <= i_npc;
                r_ir_valid <= 1'b0;
            end
            if (w_pc_bad) r_misalign <= 1'b1;
            if (w_start) begin
                r_imem_req  <= 1'b1;
                r_imem_addr <= w_pc_ok ? i_npc : r_pc;
                r_cnt       <= 8'h0;
                r_ir_valid  <= 1'b0;
            end
            if (!w_idle) r_cnt <= r_cnt + 8'h1;
            if (w_ack) begin
                r_ir       <= i_imem_rdata;
                r_ir_valid <= 1'b1;
                r_imem_req <= 1'b0;
            end
            if (w_tmo) begin
                r_imem_req  <= 1'b0;
                r_fetch_err <= 1'b1;
            end
        end
    end
    assign o_pc        = r_pc;
    assign o_ir        = r_ir;
    assign o_ir_valid  = r_ir_valid;
    assign o_misalign  = r_misalign;
    assign o_fetch_err = r_fetch_err;
    assign o_imem_req  = r_imem_req;
    assign o_imem_addr = r_imem_addr;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed self-checking bench for pc_fetch_unit
// (RESET_PC = 0x3000, TIMEOUT = 4).
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] npc = 32'h0;
    logic        pc_wr = 1'b0;
    logic        fetch_start = 1'b0;
    logic [31:0] pc, ir, imem_addr;
    logic        ir_valid, busy, misalign, fetch_err, imem_req;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_ack = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          n;

    pc_fetch_unit #(.RESET_PC(32'h0000_3000), .TIMEOUT(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_npc(npc), .i_pc_wr(pc_wr),
        .i_fetch_start(fetch_start), .o_pc(pc), .o_ir(ir), .o_ir_valid(ir_valid),
        .o_busy(busy), .o_misalign(misalign), .o_fetch_err(fetch_err),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_rdata(imem_rdata), .i_imem_ack(imem_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_reset();
        chk("rst_pc", pc, 32'h3000);
        chk("rst_addr", imem_addr, 32'h3000);
        chk("rst_ir", ir, 32'h0);
        chk("rst_irv", 32'(ir_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_mis", 32'(misalign), 32'h0);
        chk("rst_ferr", 32'(fetch_err), 32'h0);
    endtask

    initial begin
        step(); step();
        rst_n = 1'b1;
        chk_idle_reset();

        // basic fetch, ack on the third WAIT edge
        fetch_start = 1'b1; step(); fetch_start = 1'b0;
        chk("f1_req", 32'(imem_req), 32'h1);
        chk("f1_busy", 32'(busy), 32'h1);
        chk("f1_addr", imem_addr, 32'h3000);
        step(); step();
        chk("f1_req_hold", 32'(imem_req), 32'h1);
        chk("f1_addr_hold", imem_addr, 32'h3000);
        imem_ack = 1'b1; imem_rdata = 32'h2002_0005; step(); imem_ack = 1'b0;
        chk("f1_ir", ir, 32'h2002_0005);
        chk("f1_irv", 32'(ir_valid), 32'h1);
        chk("f1_req_drop", 32'(imem_req), 32'h0);
        chk("f1_busy_drop", 32'(busy), 32'h0);

        // simultaneous pc_wr + fetch_start fetches from the new pc
        npc = 32'h3010; pc_wr = 1'b1; fetch_start = 1'b1; step();
        pc_wr = 1'b0; fetch_start = 1'b0;
        chk("f2_pc", pc, 32'h3010);
        chk("f2_addr", imem_addr, 32'h3010);
        chk("f2_irv", 32'(ir_valid), 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h0000_0008; step(); imem_ack = 1'b0;
        chk("f2_ir", ir, 32'h0000_0008);
        chk("f2_irv1", 32'(ir_valid), 32'h1);

        // ack on the 4th WAIT edge beats the timeout; pc_wr in WAIT is ignored
        fetch_start = 1'b1; step(); fetch_start = 1'b0;
        npc = 32'h4000; pc_wr = 1'b1; step();
        npc = 32'h4003; step(); pc_wr = 1'b0;
        step();
        chk("t1_pc_wait", pc, 32'h3010);
        chk("t1_mis_wait", 32'(misalign), 32'h0);
        chk("t1_req", 32'(imem_req), 32'h1);
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_0001; step(); imem_ack = 1'b0;
        chk("t1_ir", ir, 32'hCAFE_0001);
        chk("t1_irv", 32'(ir_valid), 32'h1);
        chk("t1_ferr", 32'(fetch_err), 32'h0);
        chk("t1_req_drop", 32'(imem_req), 32'h0);

        // no ack: req high exactly 4 cycles, then fetch_err
        fetch_start = 1'b1; step(); fetch_start = 1'b0;
        n = 0;
        while (imem_req && n < 10) begin step(); n++; end
        chk("t2_req_cycles", 32'(n), 32'd4);
        chk("t2_ferr", 32'(fetch_err), 32'h1);
        chk("t2_irv", 32'(ir_valid), 32'h0);
        chk("t2_busy", 32'(busy), 32'h0);
        step();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; step(); imem_ack = 1'b0;
        chk("t2_late_ir", ir, 32'hCAFE_0001);
        chk("t2_late_irv", 32'(ir_valid), 32'h0);
        fetch_start = 1'b1; step(); fetch_start = 1'b0;
        chk("t2_halt_req", 32'(imem_req), 32'h0);

        // reset clears sticky flags
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk_idle_reset();

        // misaligned pc_wr
        npc = 32'h3010; pc_wr = 1'b1; step();
        npc = 32'h3012; step(); pc_wr = 1'b0;
        chk("m_pc", pc, 32'h3010);
        chk("m_flag", 32'(misalign), 32'h1);
        fetch_start = 1'b1; step(); fetch_start = 1'b0;
        chk("m_halt_req", 32'(imem_req), 32'h0);
        chk("m_halt_busy", 32'(busy), 32'h0);
        npc = 32'h3014; pc_wr = 1'b1; step(); pc_wr = 1'b0;
        chk("m_pc_aligned", pc, 32'h3014);
        chk("m_sticky", 32'(misalign), 32'h1);

        // reset during WAIT aborts the fetch; the late ack is ignored
        rst_n = 1'b0; step(); rst_n = 1'b1;
        fetch_start = 1'b1; step(); fetch_start = 1'b0;
        chk("r_busy", 32'(busy), 32'h1);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("r_req", 32'(imem_req), 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678; step(); imem_ack = 1'b0;
        chk_idle_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
